// File: rtl/crypto_instr_pkg.sv
// Shared constants for the crypto coprocessor instruction path.
package crypto_instr_pkg;

  localparam int unsigned CRYPTO_RESBUF_DEPTH = 4;
  localparam int unsigned CRYPTO_RD_W         = 5;

endpackage

// File: rtl/crypto_result_buffer.sv
// Result FIFO between a fixed-latency crypto FU (no backpressure) and the
// core's result channel, with credit-based issue throttling.
module crypto_result_buffer
  import crypto_instr_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned DEPTH    = CRYPTO_RESBUF_DEPTH,
  parameter type         hartid_t = logic,
  parameter type         id_t     = logic,
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W   = PTR_W + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   fu_valid_i,
  input  logic [XLEN-1:0]        fu_result_i,
  input  hartid_t                fu_hartid_i,
  input  id_t                    fu_id_i,
  input  logic [CRYPTO_RD_W-1:0] fu_rd_i,
  input  logic                   fu_we_i,
  input  logic                   issue_fire_i,
  output logic                   issue_ready_o,
  output logic                   x_result_valid_o,
  input  logic                   x_result_ready_i,
  output logic [XLEN-1:0]        x_result_data_o,
  output hartid_t                x_result_hartid_o,
  output id_t                    x_result_id_o,
  output logic [CRYPTO_RD_W-1:0] x_result_rd_o,
  output logic                   x_result_we_o,
  output logic [CNT_W-1:0]       count_o,
  output logic                   overflow_o
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("crypto_result_buffer: DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic [XLEN-1:0]        data;
    hartid_t                hartid;
    id_t                    id;
    logic [CRYPTO_RD_W-1:0] rd;
    logic                   we;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             fu_entry;
  entry_t             head;
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               inflight_q;
  logic               overflow_q;
  logic               full;
  logic               push, pop, drop;
  logic [CNT_W:0]     credit_sum;

  assign fu_entry = '{data:   fu_result_i,
                      hartid: fu_hartid_i,
                      id:     fu_id_i,
                      rd:     fu_rd_i,
                      we:     fu_we_i};

  assign full             = (count_q == CNT_W'(DEPTH));
  assign x_result_valid_o = (count_q != '0);
  assign pop              = x_result_valid_o & x_result_ready_i;
  // A full buffer still accepts a result when the head leaves in the same cycle.
  assign push             = fu_valid_i & (~full | pop);
  assign drop             = fu_valid_i & full & ~pop;

  // NOTE: storage is deliberately not reset; emptiness is tracked by count_q
  // and the outputs are gated by valid, so stale entries are never visible.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= fu_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      inflight_q <= issue_fire_i;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Credits count only registered state; a same-cycle pop is not credited.
  assign credit_sum    = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
  assign issue_ready_o = (credit_sum < (CNT_W + 1)'(DEPTH));

  assign head              = mem_q[rptr_q];
  assign x_result_data_o   = x_result_valid_o ? head.data   : '0;
  assign x_result_hartid_o = x_result_valid_o ? head.hartid : '0;
  assign x_result_id_o     = x_result_valid_o ? head.id     : '0;
  assign x_result_rd_o     = x_result_valid_o ? head.rd     : '0;
  assign x_result_we_o     = x_result_valid_o ? head.we     : 1'b0;
  assign count_o           = count_q;
  assign overflow_o        = overflow_q;

endmodule

// File: tb/tb_crypto_result_buffer.sv
// Self-checking bench for crypto_result_buffer: directed table, async reset
// sequence, and randomized traffic against a queue-based reference model.
module tb_crypto_result_buffer;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  typedef logic [1:0] hart_t;
  typedef logic [7:0] tag_t;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             fu_valid_i = 1'b0;
  logic [XLEN-1:0]  fu_result_i = '0;
  hart_t            fu_hartid_i = '0;
  tag_t             fu_id_i = '0;
  logic [4:0]       fu_rd_i = '0;
  logic             fu_we_i = 1'b0;
  logic             issue_fire_i = 1'b0;
  logic             issue_ready_o;
  logic             x_result_valid_o;
  logic             x_result_ready_i = 1'b0;
  logic [XLEN-1:0]  x_result_data_o;
  hart_t            x_result_hartid_o;
  tag_t             x_result_id_o;
  logic [4:0]       x_result_rd_o;
  logic             x_result_we_o;
  logic [2:0]       count_o;
  logic             overflow_o;

  crypto_result_buffer #(
    .XLEN(XLEN), .DEPTH(DEPTH), .hartid_t(hart_t), .id_t(tag_t)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .fu_valid_i(fu_valid_i), .fu_result_i(fu_result_i), .fu_hartid_i(fu_hartid_i),
    .fu_id_i(fu_id_i), .fu_rd_i(fu_rd_i), .fu_we_i(fu_we_i),
    .issue_fire_i(issue_fire_i), .issue_ready_o(issue_ready_o),
    .x_result_valid_o(x_result_valid_o), .x_result_ready_i(x_result_ready_i),
    .x_result_data_o(x_result_data_o), .x_result_hartid_o(x_result_hartid_o),
    .x_result_id_o(x_result_id_o), .x_result_rd_o(x_result_rd_o),
    .x_result_we_o(x_result_we_o), .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Entry fields are derived from the tag so every check can recompute them.
  function automatic logic [63:0] data_of(input tag_t id);
    return (id == 8'd1) ? 64'h1122334455667788 : {id, ~id, id, ~id, id, ~id, id, ~id};
  endfunction
  function automatic logic [4:0] rd_of(input tag_t id);
    return id[4:0] + 5'd4;
  endfunction
  function automatic logic we_of(input tag_t id);
    return id[0];
  endfunction
  function automatic hart_t hart_of(input tag_t id);
    return id[2:1];
  endfunction

  // Reference model: ordered queue of tags, sticky drop flag, one-cycle FU pipe.
  tag_t model_q[$];
  bit   model_ov = 1'b0;
  bit   model_inflight = 1'b0;

  function automatic bit model_ready();
    return (model_q.size() + int'(model_inflight)) < DEPTH;
  endfunction

  task automatic model_reset();
    model_q.delete();
    model_ov = 1'b0;
    model_inflight = 1'b0;
  endtask

  task automatic drive(input bit v, input tag_t id, input bit fire, input bit rdy);
    fu_valid_i       = v;
    fu_id_i          = id;
    fu_result_i      = data_of(id);
    fu_rd_i          = rd_of(id);
    fu_we_i          = we_of(id);
    fu_hartid_i      = hart_of(id);
    issue_fire_i     = fire;
    x_result_ready_i = rdy;
  endtask

  // Advance one rising edge and apply the same inputs to the model.
  task automatic tick();
    bit pop_now, room;
    @(posedge clk_i);
    pop_now = (model_q.size() != 0) && x_result_ready_i;
    room    = (model_q.size() < DEPTH) || pop_now;
    if (pop_now) void'(model_q.pop_front());
    if (fu_valid_i) begin
      if (room) model_q.push_back(fu_id_i);
      else      model_ov = 1'b1;
    end
    model_inflight = issue_fire_i;
  endtask

  task automatic check_outputs(input string tag, input bit ev, input int ec,
                               input bit eir, input bit eov, input tag_t ehead);
    check({tag, ".valid"}, 64'(x_result_valid_o), 64'(ev));
    check({tag, ".count"}, 64'(count_o), 64'(ec));
    check({tag, ".issue_ready"}, 64'(issue_ready_o), 64'(eir));
    check({tag, ".overflow"}, 64'(overflow_o), 64'(eov));
    if (ev) begin
      check({tag, ".id"}, 64'(x_result_id_o), 64'(ehead));
      check({tag, ".data"}, x_result_data_o, data_of(ehead));
      check({tag, ".rd"}, 64'(x_result_rd_o), 64'(rd_of(ehead)));
      check({tag, ".we"}, 64'(x_result_we_o), 64'(we_of(ehead)));
      check({tag, ".hartid"}, 64'(x_result_hartid_o), 64'(hart_of(ehead)));
    end
  endtask

  task automatic check_model(input string tag);
    check_outputs(tag, model_q.size() != 0, model_q.size(), model_ready(), model_ov,
                  (model_q.size() != 0) ? model_q[0] : 8'd0);
  endtask

  typedef struct {
    bit   fu_valid;
    tag_t id;
    bit   fire;
    bit   ready;
    bit   exp_valid;
    int   exp_count;
    bit   exp_ir;
    bit   exp_ov;
    tag_t exp_head;
  } vec_t;

  function automatic vec_t mk(bit v, int id, bit fire, bit rdy,
                              bit ev, int ec, bit eir, bit eov, int eh);
    vec_t r;
    r.fu_valid = v;  r.id = tag_t'(id); r.fire = fire; r.ready = rdy;
    r.exp_valid = ev; r.exp_count = ec; r.exp_ir = eir; r.exp_ov = eov;
    r.exp_head = tag_t'(eh);
    return r;
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vecs[$];
    int   next_id, expect_id, delivered, cyc;
    bit   pend_v, fire, rdy;
    tag_t pend_id;

    // Expected columns describe the outputs seen before that row's clock edge.
    vecs.push_back(mk(1, 1, 0, 1,  0, 0, 1, 0, 0));  // single push, ready high
    vecs.push_back(mk(0, 0, 0, 1,  1, 1, 1, 0, 1));  // visible one cycle later
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 0, 0));  // popped, empty again
    vecs.push_back(mk(1, 2, 0, 0,  0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 3, 0, 0,  1, 1, 1, 0, 2));
    vecs.push_back(mk(1, 4, 0, 0,  1, 2, 1, 0, 2));
    vecs.push_back(mk(1, 5, 0, 0,  1, 3, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0,  1, 4, 0, 0, 2));  // full, issue blocked
    vecs.push_back(mk(1, 6, 0, 1,  1, 4, 0, 0, 2));  // push+pop at full
    vecs.push_back(mk(1, 7, 0, 1,  1, 4, 0, 0, 3));  // again, across wrap
    vecs.push_back(mk(1, 8, 0, 0,  1, 4, 0, 0, 4));  // fifth push dropped
    vecs.push_back(mk(0, 0, 0, 0,  1, 4, 0, 1, 4));  // sticky overflow, head kept
    vecs.push_back(mk(0, 0, 0, 1,  1, 4, 0, 1, 4));
    vecs.push_back(mk(0, 0, 1, 0,  1, 3, 1, 1, 5));  // issue at count 3
    vecs.push_back(mk(1, 9, 0, 0,  1, 3, 0, 1, 5));  // 3 + 1 in flight
    vecs.push_back(mk(0, 0, 0, 1,  1, 4, 0, 1, 5));
    vecs.push_back(mk(0, 0, 0, 1,  1, 3, 1, 1, 6));  // ready again after a pop
    vecs.push_back(mk(0, 0, 0, 1,  1, 2, 1, 1, 7));
    vecs.push_back(mk(0, 0, 0, 1,  1, 1, 1, 1, 9));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 1, 0));

    drive(0, 0, 0, 0);
    #3;
    check_outputs("in_reset", 0, 0, 1, 0, 0);
    check("in_reset.data", x_result_data_o, 64'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk_i);
      drive(vecs[i].fu_valid, vecs[i].id, vecs[i].fire, vecs[i].ready);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_count,
                    vecs[i].exp_ir, vecs[i].exp_ov, vecs[i].exp_head);
      tick();
    end

    // Three entries queued, then reset asserted mid-cycle during a handshake.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      drive(1, tag_t'(40 + i), 0, 0);
      tick();
    end
    @(negedge clk_i);
    drive(1, 8'd99, 0, 1);
    check_model("pre_reset");
    #2;
    rst_ni = 1'b0;
    #1;
    check_outputs("async_reset", 0, 0, 1, 0, 0);
    check("async_reset.data", x_result_data_o, 64'd0);
    check("async_reset.id", 64'(x_result_id_o), 64'd0);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      check_model($sformatf("post_reset%0d", i));
      tick();
      @(negedge clk_i);
    end

    // Randomized traffic through a legal issue/FU pipe with random backpressure.
    next_id   = 16;
    expect_id = 16;
    delivered = 0;
    pend_v    = 1'b0;
    pend_id   = '0;
    cyc       = 0;
    while (delivered < 100 && cyc < 5000) begin
      if (cyc != 0) @(negedge clk_i);
      fire = model_ready() && ($urandom_range(0, 3) != 0) && (next_id < 116);
      rdy  = 1'($urandom_range(0, 1));
      drive(pend_v, pend_id, fire, rdy);
      check_model("rand");
      if (x_result_valid_o && rdy) begin
        check("rand.order", 64'(x_result_id_o), 64'(tag_t'(expect_id)));
        expect_id++;
        delivered++;
      end
      tick();
      pend_v  = fire;
      pend_id = tag_t'(next_id);
      if (fire) next_id++;
      cyc++;
    end
    check("rand.delivered", 64'(delivered), 64'd100);
    @(negedge clk_i);
    check_model("rand.final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
